// File: rtl/mux_rr_if.sv
// Channel-side and output-side signals of the registered arbitrating mux.
// The arbiter block uses the slave modport; whoever drives the requests
// and consumes y uses the master modport.
interface mux_rr_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] x;
  logic [N-1:0]   x_valid;
  logic [N-1:0]   x_ready;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [SW-1:0]  s;

  modport master (
    output x, x_valid, y_ready,
    input  x_ready, y, y_valid, s
  );

  modport slave (
    input  x, x_valid, y_ready,
    output x_ready, y, y_valid, s
  );
endinterface

// File: rtl/mux_rr_reg.sv
// N-channel arbitrating multiplexer with a single registered output word.
// MODE 0 arbitrates round-robin from a rotating pointer, MODE 1 gives fixed
// priority to the lowest index. One word per cycle sustained throughput.
module mux_rr_reg #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_rr_if.slave   bus
);
  localparam int              SW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0]   LAST = SW'(N - 1);

  logic [SW-1:0] p;
  logic [SW-1:0] p_nxt;
  logic [SW-1:0] sel;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;
  logic          hi_any;
  logic          any_vld;
  logic          load_en;
  logic          take;
  logic [W-1:0]  x_sel;

  logic [W-1:0]  y_p1;
  logic [SW-1:0] s_p1;
  logic          vld_p1;

  // Stage 0: arbitration. The upward scan from p with wrap is split into
  // "lowest valid at or above p" and "lowest valid overall"; the first wins
  // when present. With p held at 0 this reduces to fixed priority.
  always_comb begin
    hi_any  = 1'b0;
    any_vld = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.x_valid[k]) begin
        any_vld = 1'b1;
        lo_idx  = SW'(k);
        if ((MODE == 0) && (SW'(k) >= p)) begin
          hi_any = 1'b1;
          hi_idx = SW'(k);
        end
      end
    end
    sel = hi_any ? hi_idx : lo_idx;
  end

  // Select the granted channel's data word
  always_comb begin
    x_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == sel) x_sel = bus.x[k*W +: W];
    end
  end

  // Grant control: the register may load when empty or draining this cycle;
  // reset blocks grants so no transfer-in is signalled while held in reset
  always_comb begin
    load_en = !vld_p1 || bus.y_ready;
    take    = rst_n && load_en && any_vld;
    if (MODE != 0)       p_nxt = '0;
    else if (sel == LAST) p_nxt = '0;
    else                 p_nxt = sel + 1'b1;
  end

  assign bus.x_ready = take ? (N'(1) << sel) : '0;

  // Stage 1: output register and pointer; load on grant, clear on drain
  // without refill, hold everything under back-pressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      y_p1   <= '0;
      s_p1   <= '0;
      p      <= '0;
    end else if (take) begin
      vld_p1 <= 1'b1;
      y_p1   <= x_sel;
      s_p1   <= sel;
      p      <= p_nxt;
    end else if (bus.y_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.y       = y_p1;
  assign bus.s       = s_p1;
  assign bus.y_valid = vld_p1;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: three instances (round-robin N=4, fixed priority
// N=4, round-robin N=3) share one stimulus stream. Grants come from a
// hand-derived vector table; granted words go into per-instance queues and
// are compared when each instance presents its output.
module tb_mux_rr_reg;
  logic        clk;
  logic        rst_n;
  logic [31:0] x_d;
  logic [3:0]  xv_d;
  logic        yr_d;

  typedef struct {
    logic [7:0] y;
    logic [1:0] s;
  } exp_t;

  typedef struct {
    logic [3:0]       xv;
    logic             yr;
    logic [2:0][3:0]  rdy;   // {inst2, inst1, inst0}
  } vec_t;

  exp_t sb [3][$];
  exp_t last [3];
  vec_t va [10];
  vec_t vb [8];
  int   n_tot;
  int   n_pass;

  logic [3:0] rdy_a [3];
  logic       yv_a  [3];
  logic [7:0] yo_a  [3];
  logic [1:0] so_a  [3];

  mux_rr_if #(.W(8), .N(4)) if0 ();
  mux_rr_if #(.W(8), .N(4)) if1 ();
  mux_rr_if #(.W(8), .N(3)) if2 ();

  mux_rr_reg #(.W(8), .N(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_rr_reg #(.W(8), .N(4), .MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mux_rr_reg #(.W(8), .N(3), .MODE(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.x = x_d;        assign if0.x_valid = xv_d;      assign if0.y_ready = yr_d;
  assign if1.x = x_d;        assign if1.x_valid = xv_d;      assign if1.y_ready = yr_d;
  assign if2.x = x_d[23:0];  assign if2.x_valid = xv_d[2:0]; assign if2.y_ready = yr_d;

  assign rdy_a[0] = if0.x_ready;  assign yv_a[0] = if0.y_valid;
  assign rdy_a[1] = if1.x_ready;  assign yv_a[1] = if1.y_valid;
  assign rdy_a[2] = {1'b0, if2.x_ready};  assign yv_a[2] = if2.y_valid;
  assign yo_a[0] = if0.y;  assign so_a[0] = if0.s;
  assign yo_a[1] = if1.y;  assign so_a[1] = if1.s;
  assign yo_a[2] = if2.y;  assign so_a[2] = if2.s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s i%0d y_valid", tag, d), 32'(yv_a[d]), 32'd0);
      chk($sformatf("%s i%0d y", tag, d), 32'(yo_a[d]), 32'd0);
      chk($sformatf("%s i%0d s", tag, d), 32'(so_a[d]), 32'd0);
      chk($sformatf("%s i%0d x_ready", tag, d), 32'(rdy_a[d]), 32'd0);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      sb[d].delete();
      last[d].y = 8'h00;
      last[d].s = 2'd0;
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    exp_t e;
    int   k;
    @(negedge clk);
    xv_d = v.xv;
    yr_d = v.yr;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s i%0d x_ready", tag, d), 32'(rdy_a[d]), 32'(v.rdy[d]));
      chk($sformatf("%s i%0d y_valid", tag, d), 32'(yv_a[d]), 32'(sb[d].size() != 0));
      if (yv_a[d] && (sb[d].size() != 0)) begin
        chk($sformatf("%s i%0d y", tag, d), 32'(yo_a[d]), 32'(sb[d][0].y));
        chk($sformatf("%s i%0d s", tag, d), 32'(so_a[d]), 32'(sb[d][0].s));
        if (v.yr) begin
          last[d] = sb[d][0];
          sb[d].delete(0);
        end
      end else if (!yv_a[d]) begin
        chk($sformatf("%s i%0d held y", tag, d), 32'(yo_a[d]), 32'(last[d].y));
        chk($sformatf("%s i%0d held s", tag, d), 32'(so_a[d]), 32'(last[d].s));
      end
      if (d == 2) chk($sformatf("%s i2 s range", tag), 32'(so_a[2] < 2'd3), 32'd1);
      if (v.rdy[d] != 4'd0) begin
        k   = oh_idx(v.rdy[d]);
        e.y = x_d[k*8 +: 8];
        e.s = 2'(k);
        sb[d].push_back(e);
      end
    end
  endtask

  initial begin
    n_tot  = 0;
    n_pass = 0;
    x_d    = 32'h44332211;
    xv_d   = 4'hF;
    yr_d   = 1'b1;
    rst_n  = 1'b0;
    clear_model();

    // all valid, free-running, then back-pressure while inst0 holds 8'h22
    va[0] = '{4'hF, 1'b1, 12'h111};
    va[1] = '{4'hF, 1'b1, 12'h212};
    va[2] = '{4'hF, 1'b1, 12'h414};
    va[3] = '{4'hF, 1'b1, 12'h118};
    va[4] = '{4'hF, 1'b1, 12'h211};
    va[5] = '{4'hF, 1'b1, 12'h412};
    va[6] = '{4'hF, 1'b0, 12'h000};
    va[7] = '{4'hF, 1'b0, 12'h000};
    va[8] = '{4'hF, 1'b0, 12'h000};
    va[9] = '{4'hF, 1'b1, 12'h114};
    // after reset: sparse 1010, then 1110 (fixed priority starves 2 and 3), drain
    vb[0] = '{4'hA, 1'b1, 12'h222};
    vb[1] = '{4'hA, 1'b1, 12'h228};
    vb[2] = '{4'hA, 1'b1, 12'h222};
    vb[3] = '{4'hE, 1'b1, 12'h424};
    vb[4] = '{4'hE, 1'b1, 12'h228};
    vb[5] = '{4'hE, 1'b1, 12'h422};
    vb[6] = '{4'h0, 1'b1, 12'h000};
    vb[7] = '{4'h0, 1'b0, 12'h000};

    // power-on reset with requests pending: no grants, outputs zero
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    xv_d  = 4'h0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step($sformatf("a%0d", i), va[i]);

    // mid-cycle reset while every instance holds a word
    @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++)
      chk($sformatf("pre-rst i%0d y_valid", d), 32'(yv_a[d]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    @(negedge clk);
    #1;
    check_reset("mid hold");
    xv_d  = 4'h0;
    rst_n = 1'b1;
    clear_model();

    for (int i = 0; i < 8; i++) step($sformatf("b%0d", i), vb[i]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 Parameter W, default 8: data width per channel, W >= 1.
REQ-002 Parameter N, default 4: channel count, N >= 2.
REQ-003 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-004 Port clk  input  1: sole clock, all state updates on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port x  input  N*W: channel data, channel k at bits [k*W+W-1 : k*W].
REQ-007 Port x_valid  input  N: per-channel request, bit k = channel k holds valid data.
REQ-008 Port x_ready  output  N: per-channel grant, combinational, one-hot or zero.
REQ-009 Port y  output  W: registered selected data.
REQ-010 Port y_valid  output  1: y holds an unconsumed word.
REQ-011 Port y_ready  input  1: downstream accepts y this cycle.
REQ-012 Port s  output  clog2(N): registered index of the channel that produced y.

Function
REQ-013 Transfer in on channel k SHALL occur in a cycle where x_valid[k] and x_ready[k] are both 1; transfer out SHALL occur where y_valid and y_ready are both 1.
REQ-014 Output register SHALL be able to load when y_valid = 0 or y_ready = 1 ("load_en"); x_ready SHALL be all zeros when load_en = 0.
REQ-015 With load_en = 1 and at least one x_valid bit set, exactly one x_ready bit SHALL be 1, chosen by the arbiter; with no x_valid bits set, x_ready SHALL be zero.
REQ-016 MODE 0: arbiter SHALL grant the first valid channel found scanning upward from priority pointer p, wrapping from N-1 to 0.
REQ-017 MODE 0: after a grant to channel k, p SHALL become (k+1) mod N on the same edge; p SHALL be unchanged in cycles without a grant.
REQ-018 MODE 1: arbiter SHALL grant the lowest-index valid channel; p is unused and held at 0.
REQ-019 On a grant to channel k, the next edge SHALL load y <= x[k] and s <= k, and set y_valid <= 1; latency is one cycle, with no combinational path from x to y.
REQ-020 A transfer out with no new grant in the same cycle SHALL clear y_valid; y and s SHALL hold their last values.
REQ-021 A transfer out with a grant in the same cycle SHALL replace y and s and keep y_valid = 1, giving sustained throughput of one word per cycle.
REQ-022 With y_valid = 1 and y_ready = 0, y, s, y_valid and p SHALL remain stable.
REQ-023 When x_valid changes while its channel is not granted, the block SHALL have no effect; requests are not latched.
REQ-024 When N is not a power of two, p and s SHALL never take values >= N.

Reset
REQ-025 rst_n = 0 SHALL immediately force y = 0, s = 0, y_valid = 0 and p = 0, regardless of clk.
REQ-026 During reset, x_ready SHALL be all zeros.
REQ-027 Reset asserted mid-operation SHALL discard the held word; the first grant after release SHALL follow the priority order starting at channel 0.
REQ-028 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-029 Reset: assert rst_n = 0 mid-cycle with y_valid = 1 -> y_valid, y and s read 0 before the next edge, and x_ready = 0000.
REQ-030 MODE 0, N = 4, W = 8, x_valid = 1111, y_ready = 1 held, x = {8'h44,8'h33,8'h22,8'h11} -> y reads 11, 22, 33, 44, 11... on consecutive cycles; s reads 0, 1, 2, 3, 0.
REQ-031 Back-pressure: y_ready = 0 for 3 cycles while y = 8'h22 -> y, s = 1 and y_valid held; x_ready = 0000; the next grant after release is channel 2.
REQ-032 Sparse requests, MODE 0, starting with p = 0: x_valid = 1010 -> grant channel 1, then 3, then 1; channel 0 and channel 2 are never granted.
REQ-033 MODE 1: x_valid = 1110 held -> channel 1 is granted every cycle, and channels 2 and 3 starve.
REQ-034 N = 3, MODE 0: all channels valid for 7 cycles -> s sequence is 0, 1, 2, 0, 1, 2, 0, and s never reads 3.
